// File: rtl/tape_recorder.sv
// Cassette capture path: decodes the PLA CASS_OUT pulse stream into framed bytes
// and writes them sequentially into the SDRAM tape region over a req/ready port.
module tape_recorder #(
   parameter int unsigned CNT_W      = 12,
   parameter int unsigned THRESH     = 24,
   parameter int unsigned TIMEOUT    = 200,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce_meas,
   input  logic        arm,
   input  logic        cass,
   input  logic        sdram_available,
   input  logic        sdram_ready,
   output logic [15:0] addr,
   output logic [7:0]  data,
   output logic        req,
   output logic [15:0] length,
   output logic        recording,
   output logic        overflow,
   output logic        full
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned FCNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [CNT_W-1:0]  THRESH_C  = CNT_W'(THRESH);
   localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [FCNT_W-1:0] FIFO_CAP  = FCNT_W'(FIFO_DEPTH);
   localparam logic [15:0]       ADDR_LAST = 16'hFFFF;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DATA  = 2'd1;
   localparam logic [1:0] S_STOP1 = 2'd2;
   localparam logic [1:0] S_STOP2 = 2'd3;

   // ---------------------------------------------------------------
   // Input conditioning and cycle measurement
   // ---------------------------------------------------------------
   logic             cass_m, cass_s, cass_d;
   logic             arm_q, arm_rise;
   logic             rise, edge_pend, edge_hit;
   logic [CNT_W-1:0] cnt, cnt_inc;
   logic             primed, half;
   logic             sym, is_long, timeout;
   logic             bit_ok, bit_val, frame_err;

   assign rise     = cass_s & ~cass_d;
   assign arm_rise = arm & ~arm_q;
   assign edge_hit = ce_meas & (edge_pend | rise);
   assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
   assign is_long  = (cnt >= THRESH_C);
   assign timeout  = ce_meas & ~edge_hit & (cnt_inc == TIMEOUT_C) & (cnt != TIMEOUT_C);

   // A symbol needs a previous edge as reference; the first edge only primes.
   assign sym       = arm & edge_hit & primed;
   assign bit_ok    = sym & (is_long != half);
   assign bit_val   = ~is_long;
   assign frame_err = sym & is_long & half;

   always_ff @(posedge clk) begin
      if (reset) begin
         cass_m    <= 1'b0;
         cass_s    <= 1'b0;
         cass_d    <= 1'b0;
         arm_q     <= 1'b0;
         edge_pend <= 1'b0;
         cnt       <= '0;
         primed    <= 1'b0;
         half      <= 1'b0;
      end else begin
         cass_m <= cass;
         cass_s <= cass_m;
         cass_d <= cass_s;
         arm_q  <= arm;

         if (ce_meas)
            edge_pend <= 1'b0;
         else if (rise)
            edge_pend <= 1'b1;

         if (arm_rise)
            cnt <= '0;
         else if (ce_meas)
            cnt <= edge_hit ? CNT_W'(1) : cnt_inc;

         if (!arm || arm_rise || timeout) begin
            primed <= 1'b0;
            half   <= 1'b0;
         end else begin
            if (edge_hit)
               primed <= 1'b1;
            // half marks one short cycle seen, waiting for its partner
            if (sym)
               half <= ~is_long & ~half;
         end
      end
   end

   // ---------------------------------------------------------------
   // Framer FSM
   // ---------------------------------------------------------------
   logic [1:0] state, state_nxt;
   logic [7:0] shreg, shreg_nxt;
   logic [2:0] bitcnt, bitcnt_nxt;
   logic       push;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         shreg  <= '0;
         bitcnt <= '0;
      end else begin
         state  <= state_nxt;
         shreg  <= shreg_nxt;
         bitcnt <= bitcnt_nxt;
      end
   end

   // A framing error returns to IDLE without treating its bit 0 as a start bit.
   always_comb begin
      state_nxt  = state;
      shreg_nxt  = shreg;
      bitcnt_nxt = bitcnt;
      push       = 1'b0;
      if (!arm || arm_rise || timeout || frame_err) begin
         state_nxt = S_IDLE;
      end else if (bit_ok) begin
         case (state)
            S_IDLE: begin
               if (!bit_val) begin
                  state_nxt  = S_DATA;
                  bitcnt_nxt = '0;
               end
            end
            S_DATA: begin
               shreg_nxt  = {shreg[6:0], bit_val};
               bitcnt_nxt = bitcnt + 3'd1;
               if (bitcnt == 3'd7)
                  state_nxt = S_STOP1;
            end
            S_STOP1: state_nxt = bit_val ? S_STOP2 : S_IDLE;
            S_STOP2: begin
               state_nxt = S_IDLE;
               push      = bit_val;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Byte FIFO between framer and writer
   // ---------------------------------------------------------------
   logic [7:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [FCNT_W-1:0] fcount;
   logic              fifo_empty, fifo_full, push_ok, drop_ovf, pop;

   assign fifo_empty = (fcount == '0);
   assign fifo_full  = (fcount == FIFO_CAP);
   assign push_ok    = push & ~full & ~fifo_full;
   assign drop_ovf   = push & ~full & fifo_full;
   assign pop        = req & sdram_ready & ~arm_rise;

   always_ff @(posedge clk) begin
      if (reset || arm_rise) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fcount <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   fcount <= fcount + FCNT_W'(1);
            2'b01:   fcount <= fcount - FCNT_W'(1);
            default: fcount <= fcount;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= shreg;
   end

   // ---------------------------------------------------------------
   // SDRAM writer
   // ---------------------------------------------------------------
   logic commit, last_commit, full_after;

   assign commit      = req & sdram_ready;
   assign last_commit = commit & (addr == ADDR_LAST);
   assign full_after  = ~arm_rise & (full | last_commit);

   always_ff @(posedge clk) begin
      if (reset) begin
         addr      <= '0;
         data      <= '0;
         req       <= 1'b0;
         length    <= '0;
         recording <= 1'b0;
         overflow  <= 1'b0;
         full      <= 1'b0;
      end else begin
         recording <= arm & ~full_after;
         if (arm_rise) begin
            addr     <= '0;
            length   <= '0;
            overflow <= 1'b0;
            full     <= 1'b0;
            req      <= 1'b0;
         end else begin
            if (drop_ovf)
               overflow <= 1'b1;
            if (last_commit)
               full <= 1'b1;
            if (req) begin
               if (sdram_ready) begin
                  req <= 1'b0;
                  if (!last_commit)
                     addr <= addr + 16'd1;
                  if (length != ADDR_LAST)
                     length <= length + 16'd1;
               end
            end else if (!fifo_empty && !full && sdram_available) begin
               data <= mem[rd_ptr];
               req  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tape_recorder.sv
// Bench for tape_recorder: drives framed cassette pulse trains and scoreboards
// every SDRAM write request against hand-computed address/data pairs.
`timescale 1ns/1ps
module tb_tape_recorder;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset, ce_meas, arm, cass, sdram_available;
   logic        rsp_ready, stray_ready, sdram_ready;
   logic [15:0] addr, length;
   logic [7:0]  data;
   logic        req, recording, overflow, full;

   wr_t exp_q[$];
   int  n_cmp = 0;
   int  n_fail = 0;
   int  ready_delay = 1;

   assign sdram_ready = rsp_ready | stray_ready;

   always #5 clk = ~clk;

   tape_recorder dut (
      .clk             (clk),
      .reset           (reset),
      .ce_meas         (ce_meas),
      .arm             (arm),
      .cass            (cass),
      .sdram_available (sdram_available),
      .sdram_ready     (sdram_ready),
      .addr            (addr),
      .data            (data),
      .req             (req),
      .length          (length),
      .recording       (recording),
      .overflow        (overflow),
      .full            (full)
   );

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic exp_write(input logic [15:0] a, input logic [7:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // One measurement tick every 4 clk
   initial begin
      ce_meas = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         ce_meas = 1'b1;
         @(negedge clk);
         ce_meas = 1'b0;
      end
   end

   // SDRAM responder: accept each request after ready_delay clk
   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (req) begin
            repeat (ready_delay) @(negedge clk);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
         end
      end
   end

   // Monitor: every new request is popped against the scoreboard
   initial begin
      logic req_q;
      wr_t  e;
      req_q = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (req && !req_q) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_write: got addr %h data %h, none expected", addr, data);
            end else begin
               e = exp_q.pop_front();
               if (addr !== e.addr || data !== e.data) begin
                  n_fail++;
                  $display("FAIL write: got addr %h data %h expected addr %h data %h",
                           addr, data, e.addr, e.data);
               end
            end
         end
         req_q = req;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1, "watchdog");
   end

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (!ce_meas) @(posedge clk);
      end
      @(negedge clk);
   endtask

   // One cassette cycle of n ticks, ending in a rising edge
   task automatic cyc(input int n);
      wait_ticks(n / 2);
      cass = 1'b0;
      wait_ticks(n - n / 2);
      cass = 1'b1;
   endtask

   task automatic send_bit(input logic b);
      if (b) begin
         cyc(12);
         cyc(12);
      end else begin
         cyc(30);
      end
   endtask

   task automatic send_frame(input logic [7:0] b);
      send_bit(1'b0);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      send_bit(1'b1);
      send_bit(1'b1);
   endtask

   // Let the measurement time out, then give the reference edge
   task automatic prime();
      wait_ticks(210);
      cass = 1'b0;
      wait_ticks(6);
      cass = 1'b1;
   endtask

   task automatic rearm();
      arm = 1'b0;
      repeat (3) @(negedge clk);
      arm = 1'b1;
      @(negedge clk);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || req) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      check("drain_pending", 16'(exp_q.size()), 16'd0);
   endtask

   initial begin
      logic [7:0] partial;
      reset = 1'b1;
      arm = 1'b0;
      cass = 1'b1;
      sdram_available = 1'b1;
      stray_ready = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_addr", addr, 16'h0000);
      check("rst_data", 16'(data), 16'h0000);
      check("rst_length", length, 16'h0000);
      check("rst_req", 16'(req), 16'h0);
      check("rst_recording", 16'(recording), 16'h0);
      check("rst_overflow", 16'(overflow), 16'h0);
      check("rst_full", 16'(full), 16'h0);

      // Single full frame
      rearm();
      check("t1_recording", 16'(recording), 16'h1);
      exp_write(16'h0000, 8'hA5);
      prime();
      send_frame(8'hA5);
      wait_ticks(4);
      drain();
      check("t1_length", length, 16'h0001);
      check("t1_addr", addr, 16'h0001);

      // Back-to-back bytes with slow ready
      ready_delay = 10;
      rearm();
      check("t2_length_clear", length, 16'h0000);
      exp_write(16'h0000, 8'h00);
      exp_write(16'h0001, 8'hFF);
      exp_write(16'h0002, 8'h55);
      exp_write(16'h0003, 8'h12);
      exp_write(16'h0004, 8'h80);
      prime();
      send_frame(8'h00);
      send_frame(8'hFF);
      send_frame(8'h55);
      send_frame(8'h12);
      send_frame(8'h80);
      wait_ticks(4);
      drain();
      check("t2_length", length, 16'h0005);
      check("t2_addr", addr, 16'h0005);
      check("t2_overflow", 16'(overflow), 16'h0);
      stray_ready = 1'b1;
      @(negedge clk);
      stray_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("t2_stray_ready_length", length, 16'h0005);
      check("t2_stray_ready_addr", addr, 16'h0005);
      ready_delay = 1;

      // Framing error: STOP1 sent as a long cycle
      rearm();
      prime();
      partial = 8'h77;
      send_bit(1'b0);
      for (int i = 7; i >= 0; i--) send_bit(partial[i]);
      send_bit(1'b0);
      wait_ticks(4);
      check("t3_no_req", 16'(req), 16'h0);
      check("t3_length", length, 16'h0000);
      exp_write(16'h0000, 8'h3C);
      send_frame(8'h3C);
      wait_ticks(4);
      drain();
      check("t3_length_after", length, 16'h0001);

      // Timeout mid-DATA after 4 bits
      rearm();
      prime();
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      wait_ticks(250);
      check("t4_length", length, 16'h0000);
      exp_write(16'h0000, 8'h11);
      prime();
      send_frame(8'h11);
      wait_ticks(4);
      drain();
      check("t4_length_after", length, 16'h0001);

      // Overflow with SDRAM unavailable
      sdram_available = 1'b0;
      rearm();
      prime();
      send_frame(8'h01);
      send_frame(8'h02);
      send_frame(8'h03);
      send_frame(8'h04);
      wait_ticks(3);
      check("t5_overflow_at_4", 16'(overflow), 16'h0);
      send_frame(8'h05);
      wait_ticks(3);
      check("t5_overflow_at_5", 16'(overflow), 16'h1);
      send_frame(8'h06);
      wait_ticks(3);
      check("t5_no_req_unavail", 16'(req), 16'h0);
      exp_write(16'h0000, 8'h01);
      exp_write(16'h0001, 8'h02);
      exp_write(16'h0002, 8'h03);
      exp_write(16'h0003, 8'h04);
      sdram_available = 1'b1;
      drain();
      repeat (20) @(negedge clk);
      check("t5_length", length, 16'h0004);
      check("t5_overflow_sticky", 16'(overflow), 16'h1);

      // Last address: the write to 0xFFFF sets full
      rearm();
      force dut.addr = 16'hFFFF;
      exp_write(16'hFFFF, 8'h5A);
      prime();
      send_frame(8'h5A);
      wait_ticks(4);
      drain();
      @(negedge clk);
      check("t6_full", 16'(full), 16'h1);
      check("t6_recording", 16'(recording), 16'h0);
      check("t6_length", length, 16'h0001);
      release dut.addr;
      prime();
      send_frame(8'h66);
      wait_ticks(8);
      check("t6_drop_no_overflow", 16'(overflow), 16'h0);
      check("t6_drop_no_req", 16'(req), 16'h0);
      check("t6_length_hold", length, 16'h0001);
      check("t6_full_sticky", 16'(full), 16'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/tape_recorder.md
Name: tape_recorder

Overview:
- Cassette capture path: the counterpart of the tape player.
- Decodes the Aquarius CASS_OUT pulse stream produced by the PLA into bytes and writes them sequentially into the tape region of SDRAM, using the same req/ready arbitration the player uses.
- The top level places the captured image at 0x10000 + addr so it can be replayed or saved as a CAQ file.

Parameters:
- CNT_W, 12, width of the cycle-length counter (in ce ticks)
- THRESH, 24, cycle length in ce ticks at or above which a cycle is "long"
- TIMEOUT, 200, ticks without a rising edge that abort the current frame
- FIFO_DEPTH, 4, byte buffer depth between framer and SDRAM writer (power of 2)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce_meas  in  1  measurement tick enable, one clk wide
- arm  in  1  level; recording runs while high
- cass  in  1  cassette output from PLA, asynchronous to ce
- sdram_available  in  1  high when the SDRAM port may be used (CPU refresh window)
- sdram_ready  in  1  one-clk pulse: write accepted
- addr  out  16  byte address of the current write
- data  out  8  byte being written
- req  out  1  write request, held until sdram_ready
- length  out  16  number of bytes committed
- recording  out  1  high while armed and not full
- overflow  out  1  sticky: a byte was dropped because the FIFO was full
- full  out  1  sticky: address space exhausted

Behaviour:
- Reset values: addr, data and length are 0; req, recording, overflow and full are 0. FIFO is emptied; framer is in IDLE; counter is 0.
- Rising edge of arm:
  - Clears addr, length, overflow and full.
  - Flushes the FIFO and sets the framer to IDLE.
- Falling edge of arm:
  - Stops the framer.
  - The writer keeps draining the FIFO; length stays final.
- Input conditioning:
  - cass passes through a 2-flop synchroniser.
  - A rising edge is detected on the clk domain and latched until the next ce_meas.
- Cycle measurement:
  - The counter increments on each ce_meas and saturates at all-ones.
  - On a ce_meas with a latched rising edge, the cycle length is the counter value. Classify as long if length >= THRESH, else short. The counter then restarts at 1.
  - The first edge after IDLE or a timeout only starts measurement and produces no symbol.
- Bit decode:
  - One long cycle gives bit 0.
  - Two consecutive short cycles give bit 1.
  - A long cycle arriving after a single short cycle is a framing error.
- Timeout: when the counter reaches TIMEOUT, the framer returns to IDLE and any partial byte is discarded.
- Framer states:
  - IDLE: wait for bit 0 (start bit), then go to DATA.
  - DATA: shift 8 bits MSB first, then go to STOP1.
  - STOP1: bit 1 goes to STOP2; bit 0 is a framing error and returns to IDLE.
  - STOP2: bit 1 pushes the byte to the FIFO and returns to IDLE; bit 0 is a framing error and returns to IDLE.
  - Framing error: drop the byte and go to IDLE. The offending bit 0 is NOT reused as a start bit.
- FIFO: a push when the FIFO is full drops the byte and sets overflow.
- Writer:
  - When the FIFO is not empty, req is low, full is 0 and sdram_available is 1: load data from the FIFO head and assert req on the next clk.
  - addr holds the target address.
  - req stays high regardless of sdram_available until sdram_ready.
  - On sdram_ready: pop the FIFO, deassert req, and increment addr and length in the same clk. Minimum 2 clk between writes.
- Full condition: after the write to addr 0xFFFF commits, set full and hold addr at 0xFFFF. Length saturates at 0xFFFF. Further bytes are dropped without setting overflow. recording goes low.
- sdram_ready while req is low is ignored.
- Reset mid-write: req drops immediately; the byte is lost.

Test Plan:
- Full frame: arm=1, ce_meas every 4 clk, send start(long=30 ticks), then 0xA5 MSB first (short=12 ticks, two per 1), then two stop 1s. Expect req with addr=0x0000, data=0xA5; after ready, length=1 and addr=1.
- Back-to-back: 5 bytes 0x00, 0xFF, 0x55, 0x12, 0x80 with sdram_ready delayed 10 clk. Expect 5 writes in order, no overflow, length=5.
- Framing error: STOP1 sent as long. Expect no req and length unchanged; the next valid byte 0x3C is written at addr 0.
- Timeout: stop edges for 250 ticks mid-DATA after 4 bits, then send 0x11. Expect only 0x11 written.
- Overflow: hold sdram_available=0 and send 6 bytes. Expect overflow=1 after the 5th byte; when available returns, exactly 4 bytes are written.
- Full: preload addr by sending 0x10000 bytes (or force via a bench backdoor to 0xFFFF). Expect full=1, addr=0xFFFF, length=0xFFFF, and the next byte dropped with overflow=0.
